// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the fetch control unit
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    RUN       = 2'd1,
    MISS_WAIT = 2'd2,
    HALTED    = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_control_unit_if.sv
// rtl/fetch_control_unit_if.sv - fetch control bundle between controller and fetch logic
interface fetch_control_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] pc_cur;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  jump;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic                  load_use_hazard;
  logic                  icache_miss;
  logic                  icache_ready;
  logic                  halt;
  logic                  pc_write;
  logic [ADDR_WIDTH-1:0] pc_in;
  logic                  if_id_write;
  logic                  flush;
  logic                  cache_enable;
  logic [CNT_WIDTH-1:0]  stall_cnt;
  logic [CNT_WIDTH-1:0]  flush_cnt;

  modport master (
    input  pc_cur, branch_taken, branch_target, jump, jump_target,
           load_use_hazard, icache_miss, icache_ready, halt,
    output pc_write, pc_in, if_id_write, flush, cache_enable,
           stall_cnt, flush_cnt
  );

  modport slave (
    output pc_cur, branch_taken, branch_target, jump, jump_target,
           load_use_hazard, icache_miss, icache_ready, halt,
    input  pc_write, pc_in, if_id_write, flush, cache_enable,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_control_unit_sat_counter.sv
// rtl/fetch_control_unit_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_control_unit.sv
// rtl/fetch_control_unit.sv - fetch stage sequencer: redirects, miss wait, stalls, halt
module fetch_control_unit
  import fetch_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    CNT_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT[ADDR_WIDTH-1:0]
) (
  input logic                  clk,
  input logic                  reset_n,
  fetch_control_unit_if.master bus
);

  fetch_state_t          state_q, state_d;
  logic                  pend_valid_q;
  logic [ADDR_WIDTH-1:0] pend_target_q;

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  stall_inc;

  assign redirect        = bus.jump | bus.branch_taken;
  assign redirect_target = bus.jump ? bus.jump_target : bus.branch_target;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirects seen while a refill is outstanding are replayed when it completes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else if (state_q == MISS_WAIT) begin
      if (bus.icache_ready) begin
        pend_valid_q <= 1'b0;
      end else if (redirect) begin
        pend_valid_q  <= 1'b1;
        pend_target_q <= redirect_target;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        if (redirect) begin
          state_d = RUN;
        end else if (bus.icache_miss) begin
          state_d = MISS_WAIT;
        end else if (bus.load_use_hazard) begin
          state_d = RUN;
        end else if (bus.halt) begin
          state_d = HALTED;
        end
      end
      MISS_WAIT: if (bus.icache_ready) state_d = RUN;
      HALTED:    if (!bus.halt) state_d = RUN;
      default:   state_d = INIT;
    endcase
  end

  always_comb begin
    bus.pc_write     = 1'b0;
    bus.pc_in        = bus.pc_cur;
    bus.if_id_write  = 1'b0;
    bus.flush        = 1'b0;
    bus.cache_enable = 1'b1;
    if (!reset_n) begin
      bus.pc_in        = '0;
      bus.cache_enable = 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          bus.pc_write = 1'b1;
          bus.pc_in    = RESET_PC;
          bus.flush    = 1'b1;
        end
        RUN: begin
          bus.if_id_write = 1'b1;
          if (redirect) begin
            bus.pc_write = 1'b1;
            bus.pc_in    = redirect_target;
            bus.flush    = 1'b1;
          end else if (bus.icache_miss || bus.load_use_hazard || bus.halt) begin
            bus.pc_write    = 1'b1;
            bus.if_id_write = 1'b0;
          end
        end
        MISS_WAIT: begin
          if (bus.icache_ready) begin
            bus.if_id_write = 1'b1;
            if (redirect) begin
              bus.pc_write = 1'b1;
              bus.pc_in    = redirect_target;
              bus.flush    = 1'b1;
            end else if (pend_valid_q) begin
              bus.pc_write = 1'b1;
              bus.pc_in    = pend_target_q;
              bus.flush    = 1'b1;
            end
          end else begin
            bus.pc_write = 1'b1;
          end
        end
        HALTED: begin
          bus.pc_write = 1'b1;
          if (redirect) begin
            bus.pc_in = redirect_target;
            bus.flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_inc = (state_q != INIT) && !bus.if_id_write && !bus.flush;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clear (!reset_n),
    .inc   (stall_inc),
    .count (bus.stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .clear (!reset_n),
    .inc   (bus.flush),
    .count (bus.flush_cnt)
  );

endmodule

// File: tb/tb_fetch_control_unit.sv
// tb/tb_fetch_control_unit.sv - scoreboard bench for fetch_control_unit
module tb_fetch_control_unit;

  localparam int AW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int S_INIT = 0, S_RUN = 1, S_MISS = 2, S_HALT = 3;

  typedef struct {
    string      tag;
    logic       pw;
    logic [31:0] pc;
    logic       ifid;
    logic       fl;
    logic       ce;
    int         stall;
    int         flsh;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int          m_state = S_INIT;
  bit          m_pv    = 0;
  logic [31:0] m_pt    = '0;
  int          m_stall = 0;
  int          m_flush = 0;

  fetch_control_unit_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  fetch_control_unit #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .RESET_PC(32'h0000_0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_expect(input string tag, output exp_t e);
    e.tag = tag; e.pw = 0; e.pc = bus.pc_cur; e.ifid = 0; e.fl = 0; e.ce = 1;
    e.stall = m_stall; e.flsh = m_flush;
    if (!reset_n) begin
      e.pc = '0; e.ce = 0;
    end else if (m_state == S_INIT) begin
      e.pw = 1; e.pc = 32'h0; e.fl = 1;
    end else if (m_state == S_RUN) begin
      e.ifid = 1;
      if (bus.jump) begin e.pw = 1; e.pc = bus.jump_target; e.fl = 1; end
      else if (bus.branch_taken) begin e.pw = 1; e.pc = bus.branch_target; e.fl = 1; end
      else if (bus.icache_miss || bus.load_use_hazard || bus.halt) begin e.pw = 1; e.ifid = 0; end
    end else if (m_state == S_MISS) begin
      if (!bus.icache_ready) e.pw = 1;
      else begin
        e.ifid = 1;
        if (bus.jump) begin e.pw = 1; e.pc = bus.jump_target; e.fl = 1; end
        else if (bus.branch_taken) begin e.pw = 1; e.pc = bus.branch_target; e.fl = 1; end
        else if (m_pv) begin e.pw = 1; e.pc = m_pt; e.fl = 1; end
      end
    end else begin
      e.pw = 1;
      if (bus.jump) begin e.pc = bus.jump_target; e.fl = 1; end
      else if (bus.branch_taken) begin e.pc = bus.branch_target; e.fl = 1; end
    end
  endtask

  task automatic model_advance(input exp_t e);
    if (!reset_n) begin
      m_state = S_INIT; m_pv = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (m_state != S_INIT && !e.ifid && !e.fl && m_stall < CMAX) m_stall++;
    if (e.fl && m_flush < CMAX) m_flush++;
    case (m_state)
      S_INIT: m_state = S_RUN;
      S_RUN: if (!(bus.jump || bus.branch_taken)) begin
        if (bus.icache_miss) m_state = S_MISS;
        else if (!bus.load_use_hazard && bus.halt) m_state = S_HALT;
      end
      S_MISS: begin
        if (bus.icache_ready) begin m_state = S_RUN; m_pv = 0; end
        else if (bus.jump) begin m_pv = 1; m_pt = bus.jump_target; end
        else if (bus.branch_taken) begin m_pv = 1; m_pt = bus.branch_target; end
      end
      default: if (!bus.halt) m_state = S_RUN;
    endcase
  endtask

  // One clock: predict, push, sample mid-cycle, pop and compare, advance the model.
  task automatic step(input string tag);
    exp_t e, g;
    model_expect(tag, e);
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    check_val({g.tag, ".pc_write"},     64'(bus.pc_write),     64'(g.pw));
    check_val({g.tag, ".pc_in"},        64'(bus.pc_in),        64'(g.pc));
    check_val({g.tag, ".if_id_write"},  64'(bus.if_id_write),  64'(g.ifid));
    check_val({g.tag, ".flush"},        64'(bus.flush),        64'(g.fl));
    check_val({g.tag, ".cache_enable"}, 64'(bus.cache_enable), 64'(g.ce));
    check_val({g.tag, ".stall_cnt"},    64'(bus.stall_cnt),    64'(g.stall));
    check_val({g.tag, ".flush_cnt"},    64'(bus.flush_cnt),    64'(g.flsh));
    model_advance(g);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.branch_taken = 0; bus.branch_target = '0; bus.jump = 0; bus.jump_target = '0;
    bus.load_use_hazard = 0; bus.icache_miss = 0; bus.icache_ready = 0; bus.halt = 0;
  endtask

  initial begin
    reset_n = 0;
    bus.pc_cur = '0;
    idle_inputs();
    @(posedge clk);
    #1;
    step("rst0");
    step("rst1");
    reset_n = 1;
    step("init");
    bus.pc_cur = 32'h4;
    step("run_default");

    bus.pc_cur = 32'h0C; bus.branch_taken = 1; bus.branch_target = 32'h40;
    bus.jump = 1; bus.jump_target = 32'h80;
    step("jump_over_branch");
    idle_inputs(); bus.pc_cur = 32'h80;
    step("after_jump");

    bus.pc_cur = 32'h10; bus.icache_miss = 1;
    step("miss_enter");
    bus.icache_miss = 0; bus.halt = 1;
    for (int i = 0; i < 3; i++) step("miss_wait");
    bus.halt = 0; bus.icache_ready = 1;
    step("miss_ready");
    idle_inputs(); bus.pc_cur = 32'h14;
    step("miss_after");

    bus.pc_cur = 32'h30; bus.icache_miss = 1;
    step("pend_enter");
    bus.icache_miss = 0; bus.branch_taken = 1; bus.branch_target = 32'h100;
    step("pend_latch");
    idle_inputs();
    step("pend_wait");
    bus.icache_ready = 1;
    step("pend_replay");
    idle_inputs(); bus.pc_cur = 32'h100; bus.icache_miss = 1;
    step("pend_miss2");
    bus.icache_miss = 0; bus.icache_ready = 1;
    step("pend_cleared");

    idle_inputs(); bus.pc_cur = 32'h200; bus.icache_miss = 1;
    step("race_enter");
    bus.icache_miss = 0; bus.jump = 1; bus.jump_target = 32'h300;
    step("race_latch");
    bus.jump = 0; bus.branch_taken = 1; bus.branch_target = 32'h400; bus.icache_ready = 1;
    step("race_ready_redirect");
    idle_inputs();

    bus.pc_cur = 32'h20; bus.load_use_hazard = 1;
    step("load_use");
    bus.load_use_hazard = 0; bus.pc_cur = 32'h24;
    step("load_use_after");

    bus.halt = 1;
    for (int i = 0; i < 20; i++) step("halt_sat");
    bus.jump = 1; bus.jump_target = 32'h500;
    step("halt_redirect");
    bus.jump = 0;
    step("halt_hold");
    reset_n = 0;
    step("halt_reset");
    reset_n = 1;
    step("reinit");
    bus.halt = 0;

    bus.pc_cur = 32'h40; bus.icache_miss = 1;
    step("rstmiss_enter");
    bus.icache_miss = 0; bus.branch_taken = 1; bus.branch_target = 32'h600;
    step("rstmiss_latch");
    idle_inputs(); reset_n = 0;
    step("rstmiss_reset");
    reset_n = 1;
    step("rstmiss_init");
    bus.icache_miss = 1;
    step("rstmiss_miss");
    bus.icache_miss = 0; bus.icache_ready = 1;
    step("rstmiss_no_replay");
    idle_inputs();
    step("final");

    check_val("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
